// File: rtl/axi_lite_weight_regfile_pkg.sv
// Shared constants for the AXI4-Lite weight register file.
// Response codes, register indexes and CTRL bit positions.
package axi_lite_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int IDX_CTRL   = 0;
  localparam int IDX_STATUS = 1;
  localparam int IDX_CNT    = 2;
  localparam int IDX_RSVD   = 3;
  localparam int IDX_W0     = 4;

  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_LOCK   = 1;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_weight_regfile_if.sv
// AXI4-Lite bus bundle between the PS interconnect
// and the weight register file.
interface axi_lite_weight_regfile_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

endinterface

// File: rtl/axi_lite_weight_regfile_wr_capture.sv
// Independent AW / W one-deep buffers; fires a single-cycle
// write enable once both are held and no response is pending.
module axi_lite_wr_capture #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] awaddr,
  input  logic          awvalid,
  output logic          awready,
  input  logic [DW-1:0] wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic          wvalid,
  output logic          wready,
  input  logic          b_pend,
  output logic          we,
  output logic [AW-1:0] we_addr,
  output logic [DW-1:0] we_data,
  output logic [DW/8-1:0] we_strb
);

  logic aw_full;
  logic w_full;

  assign awready = en & ~aw_full;
  assign wready  = en & ~w_full;
  assign we      = aw_full & w_full & ~b_pend;

  // AW buffer: fills on handshake, drains when the write fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full <= 1'b0;
      we_addr <= '0;
    end else if (we) begin
      aw_full <= 1'b0;
    end else if (awvalid && awready) begin
      aw_full <= 1'b1;
      we_addr <= awaddr;
    end
  end

  // W buffer: same policy as AW, captured independently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_full  <= 1'b0;
      we_data <= '0;
      we_strb <= '0;
    end else if (we) begin
      w_full <= 1'b0;
    end else if (wvalid && wready) begin
      w_full  <= 1'b1;
      we_data <= wdata;
      we_strb <= wstrb;
    end
  end

endmodule

// File: rtl/axi_lite_weight_regfile.sv
// AXI4-Lite weight register file: shadow bank written over
// the bus, copied atomically to the active bank on COMMIT.
module axi_lite_weight_regfile
  import axi_lite_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_W      = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic ACLK,
  input  logic ARESETN,
  axi_lite_weight_regfile_if.slave s_axi,
  input  logic [DATA_WIDTH-1:0]       status_i,
  output logic [NUM_W*DATA_WIDTH-1:0] weights_o,
  output logic                        commit_o
);

  localparam int DW  = DATA_WIDTH;
  localparam int AW  = ADDR_WIDTH;
  localparam int SB  = DW / 8;
  localparam int LSB = $clog2(SB);
  localparam int IW  = AW - LSB;

  logic          live;
  logic          we;
  logic [AW-1:0] we_addr;
  logic [DW-1:0] we_data;
  logic [SB-1:0] we_strb;
  logic          bvalid;
  logic [1:0]    bresp;
  logic          rvalid;
  logic [1:0]    rresp;
  logic [DW-1:0] rdata;
  logic          lock;
  logic          lock_nxt;
  logic          commit_pend;
  logic [DW-1:0] cnt;
  logic [DW-1:0] shadow [NUM_W];

  logic [IW-1:0] widx;
  logic [IW-1:0] wk;
  logic [IW-1:0] ridx;
  logic [IW-1:0] rk;
  logic w_ctrl, w_ro, w_wt, w_oob, w_err;
  logic r_ctrl, r_stat, r_cnt, r_wt, r_oob;
  logic [DW-1:0] rd_val;
  logic          rd_err;
  logic          arready;
  logic          unused_bits;

  assign unused_bits = ^{s_axi.S_AXI_AWPROT,
                         s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_ARADDR[LSB-1:0],
                         we_addr[LSB-1:0]};

  axi_lite_wr_capture #(.AW(AW), .DW(DW)) u_wr (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .en      (live),
    .awaddr  (s_axi.S_AXI_AWADDR),
    .awvalid (s_axi.S_AXI_AWVALID),
    .awready (s_axi.S_AXI_AWREADY),
    .wdata   (s_axi.S_AXI_WDATA),
    .wstrb   (s_axi.S_AXI_WSTRB),
    .wvalid  (s_axi.S_AXI_WVALID),
    .wready  (s_axi.S_AXI_WREADY),
    .b_pend  (bvalid),
    .we      (we),
    .we_addr (we_addr),
    .we_data (we_data),
    .we_strb (we_strb)
  );

  assign arready             = live & ~rvalid;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_BVALID  = bvalid;
  assign s_axi.S_AXI_BRESP   = bresp;
  assign s_axi.S_AXI_RVALID  = rvalid;
  assign s_axi.S_AXI_RRESP   = rresp;
  assign s_axi.S_AXI_RDATA   = rdata;

  // Keep READY low while in reset and for the first cycle out
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) live <= 1'b0;
    else          live <= 1'b1;
  end

  // Write-side address decode and error classification
  always_comb begin
    widx   = we_addr[AW-1:LSB];
    wk     = widx - IW'(IDX_W0);
    w_ctrl = int'(widx) == IDX_CTRL;
    w_ro   = int'(widx) == IDX_STATUS ||
             int'(widx) == IDX_CNT;
    w_oob  = int'(widx) >= IDX_W0 + NUM_W;
    w_wt   = int'(widx) >= IDX_W0 && !w_oob;
    w_err  = w_ro | w_oob | (w_wt & lock);
  end

  // Byte-strobed shadow weight writes, blocked by LOCK
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_W; k++) shadow[k] <= '0;
    end else if (we && w_wt && !lock) begin
      for (int k = 0; k < NUM_W; k++) begin
        if (wk == IW'(k)) begin
          for (int b = 0; b < SB; b++) begin
            if (we_strb[b]) shadow[k][b*8 +: 8] <= we_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // CTRL: LOCK lands immediately or together with a COMMIT
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      lock        <= 1'b0;
      lock_nxt    <= 1'b0;
      commit_pend <= 1'b0;
      cnt         <= '0;
    end else begin
      if (commit_pend) begin
        commit_pend <= 1'b0;
        lock        <= lock_nxt;
        cnt         <= cnt + 1'b1;
      end
      if (we && w_ctrl && we_strb[0]) begin
        if (we_data[CTRL_COMMIT]) begin
          commit_pend <= 1'b1;
          lock_nxt    <= we_data[CTRL_LOCK];
        end else begin
          lock <= we_data[CTRL_LOCK];
        end
      end
    end
  end

  // Active bank copy and one-cycle commit strobe
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      weights_o <= '0;
      commit_o  <= 1'b0;
    end else begin
      commit_o <= commit_pend;
      if (commit_pend) begin
        for (int k = 0; k < NUM_W; k++) weights_o[k*DW +: DW] <= shadow[k];
      end
    end
  end

  // Write response: raised after the write fires, held until BREADY
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else if (we) begin
      bvalid <= 1'b1;
      bresp  <= resp_of(w_err);
    end else if (bvalid && s_axi.S_AXI_BREADY) begin
      bvalid <= 1'b0;
    end
  end

  // Read-side decode and data mux
  always_comb begin
    ridx   = s_axi.S_AXI_ARADDR[AW-1:LSB];
    rk     = ridx - IW'(IDX_W0);
    r_ctrl = int'(ridx) == IDX_CTRL;
    r_stat = int'(ridx) == IDX_STATUS;
    r_cnt  = int'(ridx) == IDX_CNT;
    r_oob  = int'(ridx) >= IDX_W0 + NUM_W;
    r_wt   = int'(ridx) >= IDX_W0 && !r_oob;
    rd_val = '0;
    rd_err = 1'b0;
    unique case (1'b1)
      r_ctrl: rd_val[CTRL_LOCK] = lock;
      r_stat: rd_val = status_i;
      r_cnt:  rd_val = cnt;
      r_wt: begin
        for (int k = 0; k < NUM_W; k++) begin
          if (rk == IW'(k)) rd_val = shadow[k];
        end
      end
      r_oob:  rd_err = 1'b1;
      default: ;
    endcase
  end

  // Read channel: data registered at the AR handshake
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else if (s_axi.S_AXI_ARVALID && arready) begin
      rvalid <= 1'b1;
      rresp  <= resp_of(rd_err);
      rdata  <= rd_val;
    end else if (rvalid && s_axi.S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_weight_regfile.sv
// Directed bench for the AXI4-Lite weight register file,
// 32-bit main instance plus a small 64-bit instance.
module tb_axi_lite_weight_regfile;
  import axi_lite_regfile_pkg::*;

  localparam int DW = 32;
  localparam int NW = 16;
  localparam int AW = 10;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic [DW-1:0]    status;
  logic [NW*DW-1:0] weights;
  logic             commit;
  logic [63:0]      status64;
  logic [4*64-1:0]  weights64;
  logic             commit64;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pulses64 = 0;
  logic [1:0] r;

  axi_lite_weight_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  axi_lite_weight_regfile_if #(.ADDR_WIDTH(8), .DATA_WIDTH(64)) b64 ();

  axi_lite_weight_regfile #(.DATA_WIDTH(DW), .NUM_W(NW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(bus),
    .status_i(status), .weights_o(weights), .commit_o(commit)
  );

  axi_lite_weight_regfile #(.DATA_WIDTH(64), .NUM_W(4), .ADDR_WIDTH(8)) dut64 (
    .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(b64),
    .status_i(status64), .weights_o(weights64), .commit_o(commit64)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) begin
    if (commit)   pulses++;
    if (commit64) pulses64++;
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_aw_w(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] s, input int aw_delay);
    int cyc;
    logic aw_hs, w_hs, aw_done, w_done;
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_AWVALID = (aw_delay == 0);
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge ACLK);
      aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin bus.S_AXI_WVALID = 1'b0;  w_done = 1'b1;  end
      cyc++;
      if (!aw_done && cyc >= aw_delay) bus.S_AXI_AWVALID = 1'b1;
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    check("aw_w_accept", 128'(aw_done && w_done), 128'(1));
  endtask

  task automatic get_b(output logic [1:0] resp);
    int cyc;
    logic got;
    cyc  = 0;
    got  = 1'b0;
    resp = 2'bxx;
    bus.S_AXI_BREADY = 1'b1;
    while (!got && cyc < 50) begin
      @(negedge ACLK);
      if (bus.S_AXI_BVALID) begin got = 1'b1; resp = bus.S_AXI_BRESP; end
      @(posedge ACLK); #1;
      cyc++;
    end
    bus.S_AXI_BREADY = 1'b0;
    check("b_seen", 128'(got), 128'(1));
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] s, input int aw_delay,
                           input logic [1:0] exp, input string tag);
    logic [1:0] resp;
    send_aw_w(a, d, s, aw_delay);
    get_b(resp);
    check(tag, 128'(resp), 128'(exp));
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                          input logic [1:0] exp_r, input string tag);
    int cyc;
    logic hs, got;
    logic [DW-1:0] d;
    logic [1:0] rr;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    hs  = 1'b0;
    cyc = 0;
    while (!hs && cyc < 50) begin
      @(negedge ACLK);
      hs = bus.S_AXI_ARREADY;
      @(posedge ACLK); #1;
      cyc++;
    end
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;
    got = 1'b0;
    d   = 'x;
    rr  = 'x;
    cyc = 0;
    while (hs && !got && cyc < 50) begin
      @(negedge ACLK);
      if (bus.S_AXI_RVALID) begin
        got = 1'b1; d = bus.S_AXI_RDATA; rr = bus.S_AXI_RRESP;
      end
      @(posedge ACLK); #1;
      cyc++;
    end
    bus.S_AXI_RREADY = 1'b0;
    check({tag, "_data"}, 128'(d), 128'(exp_d));
    check({tag, "_resp"}, 128'(rr), 128'(exp_r));
  endtask

  task automatic wr64(input logic [7:0] a, input logic [63:0] d,
                      input logic [1:0] exp, input string tag);
    int cyc;
    logic aw_hs, w_hs, got;
    logic [1:0] resp;
    b64.S_AXI_AWADDR = a;   b64.S_AXI_WDATA = d;
    b64.S_AXI_WSTRB  = '1;
    b64.S_AXI_AWVALID = 1'b1; b64.S_AXI_WVALID = 1'b1;
    cyc = 0;
    while ((b64.S_AXI_AWVALID || b64.S_AXI_WVALID) && cyc < 50) begin
      @(negedge ACLK);
      aw_hs = b64.S_AXI_AWVALID && b64.S_AXI_AWREADY;
      w_hs  = b64.S_AXI_WVALID && b64.S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_hs) b64.S_AXI_AWVALID = 1'b0;
      if (w_hs)  b64.S_AXI_WVALID = 1'b0;
      cyc++;
    end
    b64.S_AXI_AWVALID = 1'b0; b64.S_AXI_WVALID = 1'b0;
    b64.S_AXI_BREADY = 1'b1;
    got = 1'b0; resp = 2'bxx; cyc = 0;
    while (!got && cyc < 50) begin
      @(negedge ACLK);
      if (b64.S_AXI_BVALID) begin got = 1'b1; resp = b64.S_AXI_BRESP; end
      @(posedge ACLK); #1;
      cyc++;
    end
    b64.S_AXI_BREADY = 1'b0;
    check(tag, 128'(resp), 128'(exp));
  endtask

  task automatic rd64(input logic [7:0] a, input logic [63:0] exp,
                      input string tag);
    int cyc;
    logic hs, got;
    logic [63:0] d;
    b64.S_AXI_ARADDR = a; b64.S_AXI_ARVALID = 1'b1;
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 50) begin
      @(negedge ACLK); hs = b64.S_AXI_ARREADY;
      @(posedge ACLK); #1; cyc++;
    end
    b64.S_AXI_ARVALID = 1'b0; b64.S_AXI_RREADY = 1'b1;
    got = 1'b0; d = 'x; cyc = 0;
    while (hs && !got && cyc < 50) begin
      @(negedge ACLK);
      if (b64.S_AXI_RVALID) begin got = 1'b1; d = b64.S_AXI_RDATA; end
      @(posedge ACLK); #1; cyc++;
    end
    b64.S_AXI_RREADY = 1'b0;
    check(tag, 128'(d), 128'(exp));
  endtask

  initial begin
    status = '0;
    status64 = '0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    b64.S_AXI_AWADDR = '0; b64.S_AXI_AWPROT = '0; b64.S_AXI_AWVALID = 1'b0;
    b64.S_AXI_WDATA = '0;  b64.S_AXI_WSTRB = '0;  b64.S_AXI_WVALID = 1'b0;
    b64.S_AXI_BREADY = 1'b0;
    b64.S_AXI_ARADDR = '0; b64.S_AXI_ARPROT = '0; b64.S_AXI_ARVALID = 1'b0;
    b64.S_AXI_RREADY = 1'b0;

    // reset state
    repeat (3) @(posedge ACLK); #1;
    check("rst_awready", 128'(bus.S_AXI_AWREADY), 128'(0));
    check("rst_arready", 128'(bus.S_AXI_ARREADY), 128'(0));
    check("rst_bvalid",  128'(bus.S_AXI_BVALID), 128'(0));
    check("rst_rvalid",  128'(bus.S_AXI_RVALID), 128'(0));
    check("rst_commit",  128'(commit), 128'(0));
    check("rst_weights", 128'(|weights), 128'(0));
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK); #1;
    check("idle_awready", 128'(bus.S_AXI_AWREADY), 128'(1));
    check("idle_wready",  128'(bus.S_AXI_WREADY), 128'(1));
    check("idle_arready", 128'(bus.S_AXI_ARREADY), 128'(1));

    // sequential writes then reads
    axi_write(10'h10, 32'd1, 4'hF, 0, RESP_OKAY, "wr_w0");
    axi_write(10'h14, 32'd2, 4'hF, 0, RESP_OKAY, "wr_w1");
    axi_write(10'h18, 32'd3, 4'hF, 0, RESP_OKAY, "wr_w2");
    axi_write(10'h1C, 32'd4, 4'hF, 0, RESP_OKAY, "wr_w3");
    axi_read(10'h10, 32'd1, RESP_OKAY, "rd_w0");
    axi_read(10'h14, 32'd2, RESP_OKAY, "rd_w1");
    axi_read(10'h18, 32'd3, RESP_OKAY, "rd_w2");
    axi_read(10'h1C, 32'd4, RESP_OKAY, "rd_w3");
    check("pre_commit_weights", 128'(|weights), 128'(0));

    // commit
    axi_write(10'h00, 32'h1, 4'hF, 0, RESP_OKAY, "wr_commit");
    repeat (3) @(posedge ACLK); #1;
    check("commit_pulses", 128'(pulses), 128'(1));
    check("act_w0", 128'(weights[31:0]), 128'(1));
    check("act_w3", 128'(weights[127:96]), 128'(4));
    axi_read(10'h08, 32'd1, RESP_OKAY, "rd_cnt1");
    axi_read(10'h00, 32'd0, RESP_OKAY, "rd_ctrl0");

    // strobes, and W leading AW by 3 cycles
    axi_write(10'h10, 32'hAABBCCDD, 4'b0101, 0, RESP_OKAY, "wr_strb");
    axi_read(10'h10, 32'h00BB00DD, RESP_OKAY, "rd_strb");
    check("act_w0_stable", 128'(weights[31:0]), 128'(1));
    axi_write(10'h14, 32'h77, 4'hF, 3, RESP_OKAY, "wr_w_first");
    axi_read(10'h14, 32'h77, RESP_OKAY, "rd_w_first");

    // lock
    axi_write(10'h00, 32'h2, 4'hF, 0, RESP_OKAY, "wr_lock");
    axi_read(10'h00, 32'h2, RESP_OKAY, "rd_ctrl_lock");
    axi_write(10'h10, 32'hFFFF, 4'hF, 0, RESP_SLVERR, "wr_locked");
    axi_read(10'h10, 32'h00BB00DD, RESP_OKAY, "rd_locked");
    axi_write(10'h00, 32'h0, 4'hF, 0, RESP_OKAY, "wr_unlock");
    axi_write(10'h10, 32'hFFFF, 4'hF, 0, RESP_OKAY, "wr_unlocked");
    axi_read(10'h10, 32'hFFFF, RESP_OKAY, "rd_unlocked");

    // errors and status
    axi_read(10'h50, 32'h0, RESP_SLVERR, "rd_oob");
    axi_read(10'h3FC, 32'h0, RESP_SLVERR, "rd_oob_top");
    axi_write(10'h04, 32'h1234, 4'hF, 0, RESP_SLVERR, "wr_status");
    axi_write(10'h08, 32'h1234, 4'hF, 0, RESP_SLVERR, "wr_cnt");
    axi_write(10'h0C, 32'h1234, 4'hF, 0, RESP_OKAY, "wr_rsvd");
    axi_write(10'h50, 32'h1234, 4'hF, 0, RESP_SLVERR, "wr_oob");
    status = 32'h5A5A;
    axi_read(10'h04, 32'h5A5A, RESP_OKAY, "rd_status");
    axi_read(10'h08, 32'd1, RESP_OKAY, "rd_cnt_kept");
    axi_read(10'h0C, 32'h0, RESP_OKAY, "rd_rsvd");

    // B backpressure: second write buffered but not executed
    send_aw_w(10'h18, 32'h99, 4'hF, 0);
    repeat (5) @(posedge ACLK); #1;
    check("bp_bvalid_held", 128'(bus.S_AXI_BVALID), 128'(1));
    send_aw_w(10'h1C, 32'hAA, 4'hF, 0);
    axi_read(10'h1C, 32'd4, RESP_OKAY, "bp_blocked");
    check("bp_bvalid_still", 128'(bus.S_AXI_BVALID), 128'(1));
    get_b(r);
    check("bp_b1", 128'(r), 128'(RESP_OKAY));
    get_b(r);
    check("bp_b2", 128'(r), 128'(RESP_OKAY));
    axi_read(10'h1C, 32'hAA, RESP_OKAY, "bp_rd_w3");
    axi_read(10'h18, 32'h99, RESP_OKAY, "bp_rd_w2");

    // commit together with lock
    axi_write(10'h00, 32'h3, 4'hF, 0, RESP_OKAY, "wr_commit_lock");
    repeat (3) @(posedge ACLK); #1;
    check("commit2_pulses", 128'(pulses), 128'(2));
    check("act2_w0", 128'(weights[31:0]), 128'(32'hFFFF));
    check("act2_w1", 128'(weights[63:32]), 128'(32'h77));
    check("act2_w2", 128'(weights[95:64]), 128'(32'h99));
    check("act2_w3", 128'(weights[127:96]), 128'(32'hAA));
    axi_read(10'h08, 32'd2, RESP_OKAY, "rd_cnt2");
    axi_read(10'h00, 32'h2, RESP_OKAY, "rd_ctrl_lock2");
    axi_write(10'h20, 32'h5, 4'hF, 0, RESP_SLVERR, "wr_locked2");
    axi_write(10'h00, 32'h0, 4'hF, 0, RESP_OKAY, "wr_unlock2");

    // 64-bit instance: stride 8, low address bits ignored
    wr64(8'h20, 64'h1122334455667788, RESP_OKAY, "w64_w0");
    wr64(8'h28, 64'hCAFE, RESP_OKAY, "w64_w1");
    rd64(8'h20, 64'h1122334455667788, "r64_w0");
    rd64(8'h24, 64'h1122334455667788, "r64_w0_lowbits");
    rd64(8'h28, 64'hCAFE, "r64_w1");
    wr64(8'h00, 64'h1, RESP_OKAY, "w64_commit");
    repeat (3) @(posedge ACLK); #1;
    check("c64_pulses", 128'(pulses64), 128'(1));
    check("a64_w0", 128'(weights64[63:0]), 128'(64'h1122334455667788));
    check("a64_w1", 128'(weights64[127:64]), 128'(64'hCAFE));

    // reset in the middle of a write and a read
    bus.S_AXI_AWADDR = 10'h10; bus.S_AXI_WDATA = 32'h1234;
    bus.S_AXI_WSTRB = 4'hF;    bus.S_AXI_ARADDR = 10'h10;
    bus.S_AXI_AWVALID = 1'b1;  bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    @(posedge ACLK); #2;
    ARESETN = 1'b0;
    #1;
    check("mid_rst_bvalid",  128'(bus.S_AXI_BVALID), 128'(0));
    check("mid_rst_rvalid",  128'(bus.S_AXI_RVALID), 128'(0));
    check("mid_rst_rdata",   128'(bus.S_AXI_RDATA), 128'(0));
    check("mid_rst_awready", 128'(bus.S_AXI_AWREADY), 128'(0));
    check("mid_rst_wready",  128'(bus.S_AXI_WREADY), 128'(0));
    check("mid_rst_arready", 128'(bus.S_AXI_ARREADY), 128'(0));
    check("mid_rst_weights", 128'(|weights), 128'(0));
    check("mid_rst_w64",     128'(|weights64), 128'(0));
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    repeat (2) @(posedge ACLK); #1;
    ARESETN = 1'b1;
    repeat (4) @(posedge ACLK); #1;
    check("post_rst_no_b", 128'(bus.S_AXI_BVALID), 128'(0));
    check("post_rst_no_r", 128'(bus.S_AXI_RVALID), 128'(0));
    axi_read(10'h10, 32'h0, RESP_OKAY, "post_rst_w0");
    axi_read(10'h08, 32'h0, RESP_OKAY, "post_rst_cnt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
